// File: rtl/ps2_scancode_decoder.sv
// PS/2 set-2 scan-code decoder: tracks E0/F0 prefixes, drops typematic repeats, emits hex key strobes.
// Optional macro KEYPAD_DIGITS_EN adds numeric-keypad make codes as digits 0-9.
module ps2_scancode_decoder #(
  parameter int TIMEOUT_CYCLES = 50_000_000,
  parameter int TMR_W          = 26
) (
  input  logic       i_clock,
  input  logic       i_reset,
  input  logic       i_valid_data,
  input  logic [7:0] i_data,
  output logic       o_key_pressed,
  output logic [3:0] o_keyboard_bus,
  output logic       o_key_held
);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_EXT       = 2'd1,
    S_BREAK     = 2'd2,
    S_EXT_BREAK = 2'd3
  } state_t;

  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(1);

  state_t           r_state;
  state_t           w_state_next;
  logic [TMR_W-1:0] r_timer;
  logic [TMR_W-1:0] w_timer_next;
  logic [7:0]       r_held_code;
  logic [7:0]       w_held_code_next;
  logic             r_key_pressed;
  logic             w_key_pressed_next;
  logic [3:0]       r_keyboard_bus;
  logic [3:0]       w_keyboard_bus_next;
  logic             r_key_held;
  logic             w_key_held_next;

  logic             w_hit;
  logic [3:0]       w_hex;

  always_comb begin
    w_hit = 1'b1;
    w_hex = 4'h0;
    case (i_data)
      8'h45: w_hex = 4'h0;
      8'h16: w_hex = 4'h1;
      8'h1E: w_hex = 4'h2;
      8'h26: w_hex = 4'h3;
      8'h25: w_hex = 4'h4;
      8'h2E: w_hex = 4'h5;
      8'h36: w_hex = 4'h6;
      8'h3D: w_hex = 4'h7;
      8'h3E: w_hex = 4'h8;
      8'h46: w_hex = 4'h9;
      8'h1C: w_hex = 4'hA;
      8'h32: w_hex = 4'hB;
      8'h21: w_hex = 4'hC;
      8'h23: w_hex = 4'hD;
      8'h24: w_hex = 4'hE;
      8'h2B: w_hex = 4'hF;
`ifdef KEYPAD_DIGITS_EN
      8'h70: w_hex = 4'h0;
      8'h69: w_hex = 4'h1;
      8'h72: w_hex = 4'h2;
      8'h7A: w_hex = 4'h3;
      8'h6B: w_hex = 4'h4;
      8'h73: w_hex = 4'h5;
      8'h74: w_hex = 4'h6;
      8'h6C: w_hex = 4'h7;
      8'h75: w_hex = 4'h8;
      8'h7D: w_hex = 4'h9;
`else
`endif
      default: w_hit = 1'b0;
    endcase
  end

  always_comb begin
    w_state_next        = r_state;
    w_timer_next        = r_timer;
    w_held_code_next    = r_held_code;
    w_key_pressed_next  = 1'b0;
    w_keyboard_bus_next = r_keyboard_bus;
    w_key_held_next     = r_key_held;

    if (i_valid_data) begin
      w_timer_next = '0;
      case (r_state)
        S_IDLE: begin
          if (i_data == 8'hE0) begin
            w_state_next = S_EXT;
          end else if (i_data == 8'hF0) begin
            w_state_next = S_BREAK;
          end else if (w_hit && (i_data != r_held_code)) begin
            w_key_pressed_next  = 1'b1;
            w_keyboard_bus_next = w_hex;
            w_key_held_next     = 1'b1;
            w_held_code_next    = i_data;
          end
        end
        S_EXT: begin
          w_state_next = (i_data == 8'hF0) ? S_EXT_BREAK : S_IDLE;
        end
        S_BREAK: begin
          // Only the release of the most recently accepted key clears key_held.
          if (i_data == r_held_code) begin
            w_key_held_next  = 1'b0;
            w_held_code_next = 8'h00;
          end
          w_state_next = S_IDLE;
        end
        default: begin
          w_state_next = S_IDLE;
        end
      endcase
    end else if (r_state != S_IDLE) begin
      if (r_timer == TMR_LAST) begin
        w_state_next = S_IDLE;
        w_timer_next = '0;
      end else begin
        w_timer_next = r_timer + TMR_ONE;
      end
    end else begin
      w_timer_next = '0;
    end
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      r_state        <= S_IDLE;
      r_timer        <= '0;
      r_held_code    <= 8'h00;
      r_key_pressed  <= 1'b0;
      r_keyboard_bus <= 4'h0;
      r_key_held     <= 1'b0;
    end else begin
      r_state        <= w_state_next;
      r_timer        <= w_timer_next;
      r_held_code    <= w_held_code_next;
      r_key_pressed  <= w_key_pressed_next;
      r_keyboard_bus <= w_keyboard_bus_next;
      r_key_held     <= w_key_held_next;
    end
  end

  assign o_key_pressed  = r_key_pressed;
  assign o_keyboard_bus = r_keyboard_bus;
  assign o_key_held     = r_key_held;

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Scoreboard bench for ps2_scancode_decoder: directed scenarios, then random byte streams
// checked against a prefix-queue reference model.
module tb_ps2_scancode_decoder;

  localparam int T = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       valid = 1'b0;
  logic [7:0] data = 8'h00;
  logic       key_pressed;
  logic [3:0] keyboard_bus;
  logic       key_held;

  ps2_scancode_decoder #(.TIMEOUT_CYCLES(T), .TMR_W(5)) dut (
    .i_clock        (clk),
    .i_reset        (rst_n),
    .i_valid_data   (valid),
    .i_data         (data),
    .o_key_pressed  (key_pressed),
    .o_keyboard_bus (keyboard_bus),
    .o_key_held     (key_held)
  );

  always #5 clk = ~clk;

  typedef struct {
    int       edge_n;
    bit       strobe;
    bit [3:0] bus;
    bit       held;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   d_n = 0;
  int   m_n = 0;

  logic [7:0] pre[$];
  int         last_edge = -1000;
  logic [7:0] m_held = 8'h00;
  bit         m_key_held = 1'b0;
  bit [3:0]   m_bus = 4'h0;

  logic [7:0] hex_codes [16] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D,
                                 8'h3E, 8'h46, 8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B};
  logic [7:0] pad_codes [10] = '{8'h70, 8'h69, 8'h72, 8'h7A, 8'h6B, 8'h73, 8'h74, 8'h6C,
                                 8'h75, 8'h7D};

  function automatic int lookup(input logic [7:0] b);
    for (int i = 0; i < 16; i++) if (hex_codes[i] == b) return i;
`ifdef KEYPAD_DIGITS_EN
    for (int i = 0; i < 10; i++) if (pad_codes[i] == b) return i;
`endif
    return -1;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at edge %0d: got %0h expected %0h", name, m_n, act, exp);
    end
  endtask

  // Drive one cycle; the model is updated for the posedge these inputs will be sampled on.
  task automatic step(input bit v, input logic [7:0] b, input bit r);
    int   ed;
    int   k;
    bit   strobe;
    exp_t e;
    @(negedge clk);
    rst_n = ~r;
    valid = v;
    data  = b;
    d_n++;
    ed = d_n + 1;
    strobe = 1'b0;
    if (r) begin
      pre.delete();
      m_held = 8'h00;
      m_key_held = 1'b0;
      m_bus = 4'h0;
    end else if (v) begin
      if (pre.size() > 0 && (ed - last_edge) > T) pre.delete();
      last_edge = ed;
      if (pre.size() == 0) begin
        if (b == 8'hE0 || b == 8'hF0) begin
          pre.push_back(b);
        end else begin
          k = lookup(b);
          if (k >= 0 && b != m_held) begin
            strobe = 1'b1;
            m_bus = k[3:0];
            m_held = b;
            m_key_held = 1'b1;
          end
        end
      end else if (pre.size() == 2) begin
        pre.delete();
      end else if (pre[0] == 8'hF0) begin
        if (b == m_held) begin
          m_held = 8'h00;
          m_key_held = 1'b0;
        end
        pre.delete();
      end else begin
        if (b == 8'hF0) pre.push_back(b);
        else pre.delete();
      end
    end
    if (r || v) begin
      e.edge_n = ed;
      e.strobe = strobe;
      e.bus = m_bus;
      e.held = m_key_held;
      sb.push_back(e);
    end
    $display("step edge=%0d rst=%0b valid=%0b data=%02h exp_strobe=%0b exp_bus=%0h exp_held=%0b",
             ed, r, v, b, strobe, m_bus, m_key_held);
  endtask

  task automatic send(input logic [7:0] b);
    step(1'b1, b, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    m_n++;
    if (sb.size() > 0 && sb[0].edge_n == m_n) begin
      e = sb.pop_front();
      chk("key_pressed", {31'd0, key_pressed}, {31'd0, e.strobe});
      chk("keyboard_bus", {28'd0, keyboard_bus}, {28'd0, e.bus});
      chk("key_held", {31'd0, key_held}, {31'd0, e.held});
    end else begin
      chk("spurious_strobe", {31'd0, key_pressed}, 32'd0);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: bench did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int         r;
    int         pick;
    int         g;
    logic [7:0] b;

    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    idle(2);

    send(8'h16); idle(3);
    send(8'h1C); send(8'h1C); idle(1); send(8'h1C); idle(2);
    send(8'hF0); send(8'h1C); idle(2); send(8'h1C); idle(2);
    send(8'hE0); send(8'h45); idle(2);
    send(8'hF0); idle(T); send(8'h2B); idle(2);
    send(8'hE0); idle(T - 1); send(8'h46); idle(2);
    send(8'h45); send(8'h3E); idle(1);
    send(8'hF0); send(8'h45); idle(1);
    send(8'hF0); send(8'h3E); idle(2);
    send(8'h70); idle(2);
    send(8'hE0); send(8'hF0); send(8'h24); idle(1);
    send(8'hF0); send(8'hF0); idle(1);
    send(8'h26); step(1'b0, 8'h00, 1'b0); step(1'b1, 8'h26, 1'b1); idle(2);
    send(8'h25); send(8'hF0); step(1'b0, 8'h00, 1'b1); idle(2);

    for (int n = 0; n < 2500; n++) begin
      r = $urandom_range(0, 99);
      pick = $urandom_range(0, 9);
      case (pick)
        0, 1, 2, 3: b = hex_codes[$urandom_range(0, 15)];
        4, 9:       b = (m_held != 8'h00) ? m_held : hex_codes[$urandom_range(0, 15)];
        5:          b = 8'hE0;
        6:          b = 8'hF0;
        7:          b = pad_codes[$urandom_range(0, 9)];
        default:    b = 8'($urandom_range(0, 255));
      endcase
      if (r < 2) step(1'b1, b, 1'b1);
      else if (r < 3) step(1'b0, 8'h00, 1'b1);
      else send(b);
      g = $urandom_range(0, 19);
      if (g < 12) idle(0);
      else if (g < 17) idle($urandom_range(1, 3));
      else idle(T - 2 + $urandom_range(0, 3));
    end

    idle(4);
    @(negedge clk);
    chk("scoreboard_drained", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
